// File: rtl/macro_pkg.sv
// macro_pkg
// Shared constants and types for the register-range reduce macro expander:
// default macro opcode/funct7, base RV32I opcodes and funct3 values, the
// micro-op operation enum (encoded directly as the base funct3) and the
// expander state enum.
package macro_pkg;

  localparam logic [6:0]  MACRO_OPCODE_DEF = 7'b1110111;
  localparam logic [6:0]  MACRO_FUNCT7_DEF = 7'b1011111;
  localparam logic [31:0] NOP              = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0]  OPCODE_OP        = 7'b0110011;
  localparam logic [6:0]  OPCODE_OPIMM     = 7'b0010011;

  // funct3 values carried by the macro instruction itself
  localparam logic [2:0]  MF3_ADD = 3'b111;
  localparam logic [2:0]  MF3_XOR = 3'b100;
  localparam logic [2:0]  MF3_OR  = 3'b110;
  localparam logic [2:0]  MF3_AND = 3'b101;

  // Encoded as the RV32I R-type funct3 so the encoder can use it directly.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_XOR = 3'b100,
    OP_OR  = 3'b110,
    OP_AND = 3'b111
  } macro_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  function automatic logic mf3_valid(input logic [2:0] f3);
    return (f3 == MF3_ADD) || (f3 == MF3_XOR) || (f3 == MF3_OR) || (f3 == MF3_AND);
  endfunction

  function automatic macro_op_e mf3_to_op(input logic [2:0] f3);
    macro_op_e op;
    case (f3)
      MF3_XOR: op = OP_XOR;
      MF3_OR:  op = OP_OR;
      MF3_AND: op = OP_AND;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/macro_uop_encoder.sv
// macro_uop_encoder
// Combinational micro-op builder.
//   first : 1 -> ADDI rd, rs_a, 0 ; 0 -> R-type OP rd, rd, rs_a
//   rd    : destination (and accumulator source) register
//   rs_a  : register being folded in on this micro-op
//   op    : R-type funct3 for the reduction
//   uop   : 32-bit RV32I encoding
module macro_uop_encoder
  import macro_pkg::*;
(
  input  logic        first,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs_a,
  input  logic [2:0]  op,
  output logic [31:0] uop
);

  always_comb begin
    if (first) begin
      uop = {12'd0, rs_a, 3'b000, rd, OPCODE_OPIMM};
    end else begin
      uop = {7'd0, rs_a, rd, op, rd, OPCODE_OP};
    end
  end

endmodule

// File: rtl/macro_op_expander.sv
// macro_op_expander
// Fetch-stage expander: turns "rd = OP over x[rs1]..x[rs2]" macros into a
// sequence of RV32I micro-ops and stalls fetch until the sequence is done.
// Ports:
//   clk, reset (async, active-high)
//   instr_i   : instruction from instruction memory
//   hold_i    : freeze all state
//   flush_i   : abort any expansion, emit NOP
//   instr_o   : registered instruction to IF/ID
//   stall_o   : registered; fetch holds PC while high
//   illegal_o : registered illegal-macro flag (only with MACRO_ILLEGAL_TRAP_EN)
// Build option MACRO_ILLEGAL_TRAP_EN: illegal macros become NOP + illegal_o
// instead of passing through unchanged.
//
// state     | meaning
// ST_IDLE   | pass-through / accept new macro, emits first micro-op
// ST_EXPAND | emitting R-type micro-ops, instr_i ignored
module macro_op_expander
  import macro_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned MAX_SPAN     = 32,
  parameter logic [6:0]  MACRO_OPCODE = MACRO_OPCODE_DEF,
  parameter logic [6:0]  MACRO_FUNCT7 = MACRO_FUNCT7_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_i,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic        stall_o
`ifdef MACRO_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_o
`endif
);

  localparam int unsigned SW = REG_AW + 1;

  state_e            state_q, state_d;
  logic [SW-1:0]     counter_q, counter_d;
  logic [4:0]        rd_q, rd_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  macro_op_e         op_q, op_d;
  logic [SW-1:0]     span_q, span_d;
  logic [31:0]       instr_q, instr_d;
  logic              stall_q, stall_d;
`ifdef MACRO_ILLEGAL_TRAP_EN
  logic              illegal_q, illegal_d;
`endif

  logic [REG_AW-1:0] f_rd, f_rs1, f_rs2;
  logic [SW-1:0]     f_span;
  macro_op_e         f_op;
  logic              is_macro, legal, last_uop, enc_first;
  logic [4:0]        enc_rd, enc_rs;
  macro_op_e         enc_op;
  logic [31:0]       uop;

  assign f_rd     = REG_AW'(instr_i[11:7]);
  assign f_rs1    = REG_AW'(instr_i[19:15]);
  assign f_rs2    = REG_AW'(instr_i[24:20]);
  assign f_op     = mf3_to_op(instr_i[14:12]);
  assign f_span   = {1'b0, f_rs2} - {1'b0, f_rs1} + SW'(1);
  assign is_macro = (instr_i[6:0] == MACRO_OPCODE) && (instr_i[31:25] == MACRO_FUNCT7);

  // rd inside (rs1,rs2] would clobber a source before it is read.
  assign legal = mf3_valid(instr_i[14:12]) && (f_rs1 <= f_rs2) &&
                 (f_span <= SW'(MAX_SPAN)) &&
                 !((f_rd > f_rs1) && (f_rd <= f_rs2));

  assign last_uop = (counter_q == (span_q - SW'(1)));

  // One encoder: IDLE builds the ADDI from the incoming macro, EXPAND builds
  // the R-type from the latched fields.
  assign enc_first = (state_q == ST_IDLE);
  assign enc_rd    = enc_first ? instr_i[11:7]  : rd_q;
  assign enc_rs    = enc_first ? instr_i[19:15] : 5'({1'b0, rs1_q} + counter_q);
  assign enc_op    = enc_first ? f_op : op_q;

  macro_uop_encoder u_enc (
    .first (enc_first),
    .rd    (enc_rd),
    .rs_a  (enc_rs),
    .op    (enc_op),
    .uop   (uop)
  );

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    op_d      = op_q;
    span_d    = span_q;
    instr_d   = instr_q;
    stall_d   = stall_q;
`ifdef MACRO_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    if (flush_i) begin
      state_d   = ST_IDLE;
      counter_d = '0;
      instr_d   = NOP;
      stall_d   = 1'b0;
`ifdef MACRO_ILLEGAL_TRAP_EN
      illegal_d = 1'b0;
`endif
    end else if (!hold_i) begin
      case (state_q)
        ST_IDLE: begin
`ifdef MACRO_ILLEGAL_TRAP_EN
          illegal_d = 1'b0;
`endif
          if (is_macro && legal) begin
            rd_d    = instr_i[11:7];
            rs1_d   = f_rs1;
            op_d    = f_op;
            span_d  = f_span;
            instr_d = uop;
            if (f_span == SW'(1)) begin
              stall_d = 1'b0;
            end else begin
              counter_d = SW'(1);
              state_d   = ST_EXPAND;
              stall_d   = 1'b1;
            end
          end
`ifdef MACRO_ILLEGAL_TRAP_EN
          else if (is_macro) begin
            instr_d   = NOP;
            stall_d   = 1'b0;
            illegal_d = 1'b1;
          end
`endif
          else begin
            instr_d = instr_i;
            stall_d = 1'b0;
          end
        end
        ST_EXPAND: begin
          instr_d   = uop;
          counter_d = counter_q + SW'(1);
          if (last_uop) begin
            stall_d   = 1'b0;
            state_d   = ST_IDLE;
            counter_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      op_q      <= OP_ADD;
      span_q    <= '0;
      instr_q   <= NOP;
      stall_q   <= 1'b0;
`ifdef MACRO_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      op_q      <= op_d;
      span_q    <= span_d;
      instr_q   <= instr_d;
      stall_q   <= stall_d;
`ifdef MACRO_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign instr_o = instr_q;
  assign stall_o = stall_q;
`ifdef MACRO_ILLEGAL_TRAP_EN
  assign illegal_o = illegal_q;
`endif

endmodule

// File: tb/tb_macro_op_expander.sv
// tb_macro_op_expander
// Scoreboard bench: the driver pushes one expected output per clock edge,
// derived from a list-based reference model; a monitor pops and compares
// one cycle later. MAX_SPAN is reduced to 16 so the span limit is reachable
// with 5-bit register fields. Honours MACRO_ILLEGAL_TRAP_EN.
module tb_macro_op_expander;

  localparam int          TB_MAX_SPAN = 16;
  localparam logic [31:0] NOP_W       = 32'h0000_0013;
`ifdef MACRO_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic        stall;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_i;
  logic        hold_i, flush_i;
  logic [31:0] instr_o;
  logic        stall_o;
  logic        illegal_o;

  exp_t sb[$];
  exp_t pend[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  macro_op_expander #(.MAX_SPAN(TB_MAX_SPAN)) dut (
    .clk     (clk),
    .reset   (reset),
    .instr_i (instr_i),
    .hold_i  (hold_i),
    .flush_i (flush_i),
    .instr_o (instr_o),
    .stall_o (stall_o)
`ifdef MACRO_ILLEGAL_TRAP_EN
    ,
    .illegal_o (illegal_o)
`endif
  );
`ifndef MACRO_ILLEGAL_TRAP_EN
  assign illegal_o = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int f3, input int rd, input int rs1, input int rs2);
    return {7'b1011111, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b1110111};
  endfunction

  // Reference model: the full list of outputs a fetched instruction produces.
  function automatic void model_issue(input logic [31:0] ins);
    int rd, rs1, rs2, f3, span, bf3;
    bit is_m, ok;
    exp_t e;
    rd   = int'(ins[11:7]);
    rs1  = int'(ins[19:15]);
    rs2  = int'(ins[24:20]);
    f3   = int'(ins[14:12]);
    is_m = (ins[6:0] == 7'b1110111) && (ins[31:25] == 7'b1011111);
    ok   = 1'b1;
    case (f3)
      7:       bf3 = 0;
      4:       bf3 = 4;
      6:       bf3 = 6;
      5:       bf3 = 7;
      default: begin bf3 = 0; ok = 1'b0; end
    endcase
    span = rs2 - rs1 + 1;
    if (rs1 > rs2 || span > TB_MAX_SPAN || (rd > rs1 && rd <= rs2)) ok = 1'b0;
    if (is_m && ok) begin
      for (int k = 0; k < span; k++) begin
        if (k == 0) e.instr = 32'((rs1 << 15) | (rd << 7) | 32'h13);
        else        e.instr = 32'(((rs1 + k) << 20) | (rd << 15) | (bf3 << 12) | (rd << 7) | 32'h33);
        e.stall = (k < span - 1);
        e.ill   = 1'b0;
        pend.push_back(e);
      end
    end else if (is_m && TRAP) begin
      e.instr = NOP_W; e.stall = 1'b0; e.ill = 1'b1;
      pend.push_back(e);
    end else begin
      e.instr = ins; e.stall = 1'b0; e.ill = 1'b0;
      pend.push_back(e);
    end
  endfunction

  task automatic step(input logic [31:0] ins, input logic h, input logic f);
    exp_t e;
    @(negedge clk);
    instr_i = ins;
    hold_i  = h;
    flush_i = f;
    if (f) begin
      pend.delete();
      e.instr = NOP_W; e.stall = 1'b0; e.ill = 1'b0;
    end else if (h) begin
      e = last_exp;
    end else begin
      if (pend.size() == 0) model_issue(ins);
      e = pend.pop_front();
    end
    last_exp = e;
    sb.push_back(e);
  endtask

  // Issue one instruction and let any expansion run to completion.
  task automatic run(input logic [31:0] ins);
    step(ins, 1'b0, 1'b0);
    while (pend.size() != 0) step(NOP_W, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    int r, rs1, rs2, f3;
    int vf3[4] = '{7, 4, 6, 5};
    r = int'($urandom_range(0, 9));
    if (r < 6) begin
      rs1 = int'($urandom_range(0, 31));
      if (r < 5) rs2 = (rs1 + int'($urandom_range(0, 18)) > 31) ? 31 : rs1 + int'($urandom_range(0, 18));
      else       rs2 = int'($urandom_range(0, 31));
      f3 = ($urandom_range(0, 9) < 8) ? vf3[$urandom_range(0, 3)] : int'($urandom_range(0, 7));
      return mk(f3, int'($urandom_range(0, 31)), rs1, rs2);
    end
    return $urandom;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && sb.size() > 0) begin
        e = sb.pop_front();
        chk("instr_o", instr_o, e.instr);
        chk("stall_o", 32'(stall_o), 32'(e.stall));
        if (TRAP) chk("illegal_o", 32'(illegal_o), 32'(e.ill));
      end
    end
  end

  initial begin : driver
    logic [31:0] nxt;
    logic h, f;
    reset   = 1'b1;
    instr_i = NOP_W;
    hold_i  = 1'b0;
    flush_i = 1'b0;
    last_exp.instr = NOP_W; last_exp.stall = 1'b0; last_exp.ill = 1'b0;
    #12;
    chk("reset_instr", instr_o, NOP_W);
    chk("reset_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // ADD x10 = x5..x7
    run(mk(7, 10, 5, 7));
    run(32'h0010_0093);
    // hold for two cycles on the second micro-op
    step(mk(7, 10, 5, 7), 1'b0, 1'b0);
    step(32'h0020_0113, 1'b0, 1'b0);
    step(32'h0020_0113, 1'b1, 1'b0);
    step(32'h0020_0113, 1'b1, 1'b0);
    step(32'h0020_0113, 1'b0, 1'b0);
    run(32'h0020_0113);
    // flush during expansion
    step(mk(7, 10, 5, 7), 1'b0, 1'b0);
    step(32'h0030_0193, 1'b0, 1'b0);
    step(32'h0030_0193, 1'b0, 1'b1);
    run(32'h0030_0193);
    // XOR single and pair, OR/AND, rd=x0, span limit, illegal forms
    run(mk(4, 10, 5, 5));
    run(mk(4, 10, 5, 6));
    run(mk(6, 3, 8, 11));
    run(mk(5, 20, 1, 4));
    run(mk(7, 0, 0, 15));
    run(mk(7, 31, 0, 16));
    run(mk(7, 10, 7, 5));
    run(mk(7, 6, 5, 7));
    run(mk(0, 10, 5, 7));
    run(32'h0040_0213);

    nxt = rand_instr();
    for (int i = 0; i < 2000; i++) begin
      if (pend.size() == 0) nxt = rand_instr();
      h = ($urandom_range(0, 99) < 12);
      f = ($urandom_range(0, 99) < 4);
      step(nxt, h, f);
    end
    while (pend.size() != 0) step(NOP_W, 1'b0, 1'b0);

    // asynchronous reset mid-expansion
    step(mk(7, 20, 2, 6), 1'b0, 1'b0);
    step(NOP_W, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("async_reset_instr", instr_o, NOP_W);
    chk("async_reset_stall", 32'(stall_o), 32'd0);
    if (TRAP) chk("async_reset_illegal", 32'(illegal_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    pend.delete();
    last_exp.instr = NOP_W; last_exp.stall = 1'b0; last_exp.ill = 1'b0;
    mon_en = 1'b1;
    run(mk(7, 10, 5, 7));
    run(32'h0050_0293);
    step(NOP_W, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
